// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use / branch-operand stalls and data-memory wait freezes.
// Optional saturating stall/freeze counter is built only when HAZARD_STALL_CNT_EN is defined.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

module hazard_control_unit #(
   parameter int REG_ADDR_WIDTH = `REG_ADDR_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [6:0]                IF_ID_inst_opcode,
   input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
   input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
   input  logic                      ID_EX_mem_rd_en,
   input  logic                      ID_EX_reg_wr_en,
   input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
   input  logic                      EX_MEM_mem_rd_en,
   input  logic                      EX_MEM_mem_wr_en,
   input  logic [REG_ADDR_WIDTH-1:0] EX_MEM_rd,
   input  logic                      branch_taken,
   input  logic                      dmem_ready,
   output logic                      pc_wr_en,
   output logic                      IF_ID_wr_en,
   output logic                      ID_EX_wr_en,
   output logic                      EX_MEM_wr_en,
   output logic                      IF_ID_flush,
   output logic                      ID_EX_flush,
   output logic                      MEM_WB_flush,
   output logic [15:0]               stall_cycles
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] HZ_STALL = 2'd1;
   localparam logic [1:0] MEM_WAIT = 2'd2;

   logic [1:0] state;
   logic [1:0] next_state;
   logic       ret_hz;
   logic       next_ret_hz;
   logic       is_branch;
   logic       uses_rs2;
   logic       h1;
   logic       h2;
   logic       mem_busy;
   logic       do_stall;
   logic       do_freeze;
   logic       stall_act;
   logic       freeze_act;

   function automatic logic dep(input logic [REG_ADDR_WIDTH-1:0] x,
                                input logic                      rs2_used,
                                input logic [REG_ADDR_WIDTH-1:0] rs1,
                                input logic [REG_ADDR_WIDTH-1:0] rs2);
      dep = (x != '0) && ((x == rs1) || (rs2_used && (x == rs2)));
   endfunction

   assign is_branch = (IF_ID_inst_opcode == 7'b1100011);
   assign uses_rs2  = (IF_ID_inst_opcode == 7'b0110011) ||
                      (IF_ID_inst_opcode == 7'b0100011) ||
                      (IF_ID_inst_opcode == 7'b1100011);

   // A branch compares in ID, so a load feeding it needs two bubbles (H2);
   // every other producer/consumer conflict costs one bubble (H1).
   assign h2 = is_branch && ID_EX_mem_rd_en && dep(ID_EX_rd, uses_rs2, IF_ID_rs1, IF_ID_rs2);
   assign h1 = !h2 &&
               ((ID_EX_mem_rd_en && dep(ID_EX_rd, uses_rs2, IF_ID_rs1, IF_ID_rs2)) ||
                (is_branch && ID_EX_reg_wr_en && dep(ID_EX_rd, uses_rs2, IF_ID_rs1, IF_ID_rs2)) ||
                (is_branch && EX_MEM_mem_rd_en && dep(EX_MEM_rd, uses_rs2, IF_ID_rs1, IF_ID_rs2)));
   assign mem_busy = (EX_MEM_mem_rd_en || EX_MEM_mem_wr_en) && !dmem_ready;

   always_comb begin
      next_state  = state;
      next_ret_hz = ret_hz;
      do_stall    = 1'b0;
      do_freeze   = 1'b0;
      case (state)
         IDLE: begin
            if (mem_busy) begin
               do_freeze   = 1'b1;
               next_state  = MEM_WAIT;
               next_ret_hz = 1'b0;
            end else if (h2) begin
               do_stall   = 1'b1;
               next_state = HZ_STALL;
            end else if (h1) begin
               do_stall = 1'b1;
            end
         end
         HZ_STALL: begin
            if (mem_busy) begin
               do_freeze   = 1'b1;
               next_state  = MEM_WAIT;
               next_ret_hz = 1'b1;
            end else begin
               do_stall   = 1'b1;
               next_state = IDLE;
            end
         end
         MEM_WAIT: begin
            // The cycle in which memory completes is still frozen; the pipeline moves on the next one.
            do_freeze = 1'b1;
            if (dmem_ready) begin
               next_state = ret_hz ? HZ_STALL : IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   assign stall_act  = do_stall && !rst;
   assign freeze_act = do_freeze && !rst;

   always_comb begin
      pc_wr_en     = 1'b1;
      IF_ID_wr_en  = 1'b1;
      ID_EX_wr_en  = 1'b1;
      EX_MEM_wr_en = 1'b1;
      IF_ID_flush  = 1'b0;
      ID_EX_flush  = 1'b0;
      MEM_WB_flush = 1'b0;
      if (freeze_act) begin
         pc_wr_en     = 1'b0;
         IF_ID_wr_en  = 1'b0;
         ID_EX_wr_en  = 1'b0;
         EX_MEM_wr_en = 1'b0;
         MEM_WB_flush = 1'b1;
      end else if (stall_act) begin
         pc_wr_en    = 1'b0;
         IF_ID_wr_en = 1'b0;
         ID_EX_flush = 1'b1;
      end else if (!rst) begin
         IF_ID_flush = branch_taken;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         ret_hz <= 1'b0;
      end else begin
         state  <= next_state;
         ret_hz <= next_ret_hz;
      end
   end

`ifdef HAZARD_STALL_CNT_EN
   logic [15:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= 16'd0;
      end else if ((stall_act || freeze_act) && (count != 16'hFFFF)) begin
         count <= count + 16'd1;
      end
   end

   assign stall_cycles = count;
`else
   assign stall_cycles = 16'd0;
`endif

endmodule
